// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day counter: segment patterns and unit limits.
// Latency: none (constants only).
// Backpressure: not applicable.
package clock_pkg;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Wrap limits of each time unit
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SEC_MAX  = 59;

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to seven-segment pattern; non-BCD codes go dark.
// Latency: purely combinational.
// Backpressure: none.
module seg7_dec
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the digit pattern
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_cnt.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler and manual set pulses.
// Latency: time registers update on the tick edge; set/clear pulses show one cycle later.
// Backpressure: none; every pulse is consumed in the cycle it arrives.
module time_cnt
    import clock_pkg::*;
#(
    parameter int unsigned DIV = 125_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic [6:0] hour_hi,
    output logic [6:0] hour_lo,
    output logic [6:0] min_hi,
    output logic [6:0] min_lo,
    output logic [6:0] sec_hi,
    output logic [6:0] sec_lo,
    output logic [4:0] hour_bin,
    output logic [5:0] sec_bin,
    output logic       sec_tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;
    logic [1:0]    h_t;
    logic [3:0]    h_u;
    logic [2:0]    m_t;
    logic [3:0]    m_u;
    logic [2:0]    s_t;
    logic [3:0]    s_u;

    logic tick;
    logic sec_wrap;
    logic min_wrap;
    logic min_carry;
    logic min_step;
    logic hour_step;
    logic [6:0] hour_hi_raw;

    // A clear on the tick cycle swallows the tick: no carry, no pulse
    assign tick      = !set_mode && (pre == PW'(DIV - 1));
    assign sec_wrap  = (sec_bin == 6'(SEC_MAX));
    assign min_wrap  = (m_t == 3'(MIN_MAX / 10)) && (m_u == 4'(MIN_MAX % 10));
    assign min_carry = tick && sec_wrap && !clr_sec;
    assign min_step  = min_carry || (set_mode && inc_min);
    assign hour_step = (min_carry && min_wrap) || (set_mode && inc_hour);

    // Prescaler: held at 0 in set mode so the first tick after release is DIV cycles away
    always_ff @(posedge clk) begin
        if (rst || set_mode || clr_sec) begin
            pre <= '0;
        end else if (pre == PW'(DIV - 1)) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Seconds: BCD digits and binary copy advance together
    always_ff @(posedge clk) begin
        if (rst || clr_sec) begin
            s_t     <= '0;
            s_u     <= '0;
            sec_bin <= '0;
        end else if (tick) begin
            if (sec_wrap) begin
                s_t     <= '0;
                s_u     <= '0;
                sec_bin <= '0;
            end else begin
                sec_bin <= sec_bin + 1'b1;
                if (s_u == 4'd9) begin
                    s_u <= '0;
                    s_t <= s_t + 1'b1;
                end else begin
                    s_u <= s_u + 1'b1;
                end
            end
        end
    end

    // Minutes: advanced by second carry or by a set pulse; no carry out in set mode
    always_ff @(posedge clk) begin
        if (rst) begin
            m_t <= '0;
            m_u <= '0;
        end else if (min_step) begin
            if (min_wrap) begin
                m_t <= '0;
                m_u <= '0;
            end else if (m_u == 4'd9) begin
                m_u <= '0;
                m_t <= m_t + 1'b1;
            end else begin
                m_u <= m_u + 1'b1;
            end
        end
    end

    // Hours: 23 wraps to 00 with no day carry
    always_ff @(posedge clk) begin
        if (rst) begin
            h_t      <= '0;
            h_u      <= '0;
            hour_bin <= '0;
        end else if (hour_step) begin
            if (hour_bin == 5'(HOUR_MAX)) begin
                h_t      <= '0;
                h_u      <= '0;
                hour_bin <= '0;
            end else begin
                hour_bin <= hour_bin + 1'b1;
                if (h_u == 4'd9) begin
                    h_u <= '0;
                    h_t <= h_t + 1'b1;
                end else begin
                    h_u <= h_u + 1'b1;
                end
            end
        end
    end

    // Registered tick pulse, aligned with the new time values
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick && !clr_sec;
        end
    end

    seg7_dec u_dec_hh (.bcd({2'b00, h_t}), .seg(hour_hi_raw));
    seg7_dec u_dec_hl (.bcd(h_u),          .seg(hour_lo));
    seg7_dec u_dec_mh (.bcd({1'b0, m_t}),  .seg(min_hi));
    seg7_dec u_dec_ml (.bcd(m_u),          .seg(min_lo));
    seg7_dec u_dec_sh (.bcd({1'b0, s_t}),  .seg(sec_hi));
    seg7_dec u_dec_sl (.bcd(s_u),          .seg(sec_lo));

    // Leading hour zero is blanked
    assign hour_hi = (h_t == 2'd0) ? SEG_BLANK : hour_hi_raw;

endmodule

// File: doc/time_cnt.md
# time_cnt

Real-time-of-day counter for the clock design. Divides the system clock down to a 1 Hz tick, keeps hours/minutes/seconds in BCD with a 24-hour wrap, and accepts manual set pulses. Sits directly upstream of `disp_sel`, driving its `hour_hi`…`sec_lo` segment inputs and its `hour_bin`/`sec_bin` LED inputs.

## Interface
- `DIV`, 125_000_000, system-clock cycles per second tick (≥ 2; benches use 4)
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `set_mode`  in  1  level; 1 = counting halted, set pulses accepted
- `inc_hour`  in  1  single-cycle pulse, already debounced; hour +1 in set mode
- `inc_min`  in  1  single-cycle pulse, already debounced; minute +1 in set mode
- `clr_sec`  in  1  single-cycle pulse; seconds and prescaler to 0
- `hour_hi`, `hour_lo`, `min_hi`, `min_lo`, `sec_hi`, `sec_lo`  out  7 each  segment patterns, active-high, bit order {g,f,e,d,c,b,a}
- `hour_bin`  out  5  hour, binary 0..23
- `sec_bin`  out  6  second, binary 0..59
- `sec_tick`  out  1  one-cycle pulse on each accepted second increment

## Operation
- Registers: prescaler `pre` (0..DIV-1); BCD digits `h_t`(2b), `h_u`, `m_t`(3b), `m_u`, `s_t`(3b), `s_u`; binary `hour_bin`, `sec_bin` kept in parallel with the BCD digits.
- Reset: all counters 0 → time 00:00:00, `sec_tick`=0.
- Run mode (`set_mode`=0): `pre` increments every cycle; at `pre`==DIV-1 it wraps to 0 and the tick fires. Each tick adds one second: `s_u` 9→0 carries into `s_t`; 59→00 carries into the minute; minute 59→00 carries into the hour; hour 23→00 (no day carry). `inc_hour`/`inc_min` are ignored.
- Set mode (`set_mode`=1): `pre` held at 0; no ticks; `sec_tick` stays 0. `inc_min` adds 1 to the minute, 59→00, with no carry into the hour. `inc_hour` adds 1 to the hour, 23→00. Both pulses in the same cycle: both applied independently.
- `clr_sec` (either mode): seconds → 00 and `pre` → 0 next cycle. Takes priority over a coincident tick; no minute carry results, and `sec_tick` is not raised in that cycle.
- Leaving set mode: counting resumes from `pre`=0, so the first tick comes DIV cycles later.
- Segment decode is combinational from the registered digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; non-BCD → 0000000.
- Leading-zero blank: `hour_hi`=0000000 when `h_t`==0. All other digits always show.

## Timing
- The tick cycle (`pre`==DIV-1) updates all time registers at that clock edge. `sec_tick` is registered and is high during the cycle after that edge, aligned with the new time values.
- Set pulses and `clr_sec`: the effect is visible on the outputs one cycle after the pulse cycle.
- All outputs change only on `clk` edges. Binary and segment outputs are mutually consistent in every cycle.
- `rst` mid-count: next cycle shows 00:00:00 and `pre`=0. `rst` overrides every other input.

## Structure
- `clock_pkg` holds: the segment pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`, and the limits `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59.
- One sub-module, `seg7_dec`: 4-bit BCD in, 7-bit pattern out, purely combinational. It is instantiated six times. For `hour_hi`, the blanking is applied outside the decoder.
- The carry chain is kept in the top level as one `always_ff` per time unit.

## Test plan
- Reset, hold 10 cycles → `hour_hi`=0000000, `hour_lo`/`min_*`/`sec_*`=0111111, `hour_bin`=0, `sec_bin`=0, `sec_tick`=0.
- DIV=4, run 240 cycles after reset → 60 `sec_tick` pulses, exactly 4 cycles apart; time 00:01:00, `sec_bin`=0, `min_lo`=0000110.
- Set mode: 23×`inc_hour`, 59×`inc_min`. Run; 59 ticks → 23:59:59. One more tick → 00:00:00 (`hour_bin`=0, `hour_hi` blank).
- Set mode with minute=59, `inc_min` → minute 00, hour unchanged. `inc_hour`+`inc_min` in the same cycle at 12:34 → 13:35.
- Run mode: `clr_sec` in the same cycle as a tick, at sec=59 → sec=00, minute unchanged, no `sec_tick`. 12:34:56 → `hour_lo`=1011011, `sec_lo`=1111101, `hour_bin`=12, `sec_bin`=56.
- `rst` asserted one cycle mid-count at 05:07:33 with `pre`=2 → next cycle 00:00:00; first tick arrives 4 cycles after `rst` deasserts.
